// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: grants the shared SDRAM bus to init, refresh, write or read.
// Priority is refresh > write > read, and every transaction is followed by one NOP cycle.
module sdram_arbit #(
  parameter int ADDR_W = 11,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          init_cmds,
  input  logic [ADDR_W-1:0]   init_addr,
  input  logic [BA_W-1:0]     init_ba,
  input  logic                init_done,
  input  logic                aref_req,
  input  logic                aref_end,
  input  logic [3:0]          aref_cmds,
  input  logic [ADDR_W-1:0]   aref_addr,
  input  logic [BA_W-1:0]     aref_ba,
  output logic                aref_en,
  input  logic                wr_req,
  input  logic                wr_end,
  input  logic [3:0]          wr_cmds,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [BA_W-1:0]     wr_ba,
  input  logic [DQ_W-1:0]     wr_dq,
  input  logic [DQ_W/8-1:0]   wr_dqm,
  input  logic                wr_output_en,
  output logic                wr_en,
  input  logic                rd_req,
  input  logic                rd_end,
  input  logic [3:0]          rd_cmds,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [BA_W-1:0]     rd_ba,
  input  logic [DQ_W/8-1:0]   rd_dqm,
  output logic                rd_en,
  output logic [DQ_W-1:0]     rd_dq,
  output logic [3:0]          sdr_cmds,
  output logic [ADDR_W-1:0]   sdr_addr,
  output logic [BA_W-1:0]     sdr_ba,
  output logic [DQ_W/8-1:0]   sdr_dqm,
  inout  wire  [DQ_W-1:0]     sdr_dq
);

  // state   | meaning
  // S_INIT  | bus owned by the init sequencer, waiting for init_done
  // S_ARBIT | bus idle (NOP), pick the highest-priority request
  // S_AREF  | refresh owns the bus until aref_end
  // S_WRITE | write owns the bus until wr_end
  // S_READ  | read owns the bus until rd_end
  typedef enum logic [2:0] {S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ} state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_done) state_nxt = S_ARBIT;
      S_ARBIT: begin
        if (aref_req)    state_nxt = S_AREF;
        else if (wr_req) state_nxt = S_WRITE;
        else if (rd_req) state_nxt = S_READ;
      end
      S_AREF:  if (aref_end) state_nxt = S_ARBIT;
      S_WRITE: if (wr_end)   state_nxt = S_ARBIT;
      S_READ:  if (rd_end)   state_nxt = S_ARBIT;
      default: state_nxt = S_INIT;
    endcase
  end

  // Bus mux is driven straight off the state register so commands line up with the grant.
  always_comb begin
    sdr_cmds = CMD_NOP;
    sdr_addr = '0;
    sdr_ba   = '0;
    sdr_dqm  = '1;
    case (state)
      S_INIT: begin
        sdr_cmds = init_cmds;
        sdr_addr = init_addr;
        sdr_ba   = init_ba;
      end
      S_AREF: begin
        sdr_cmds = aref_cmds;
        sdr_addr = aref_addr;
        sdr_ba   = aref_ba;
      end
      S_WRITE: begin
        sdr_cmds = wr_cmds;
        sdr_addr = wr_addr;
        sdr_ba   = wr_ba;
        sdr_dqm  = wr_dqm;
      end
      S_READ: begin
        sdr_cmds = rd_cmds;
        sdr_addr = rd_addr;
        sdr_ba   = rd_ba;
        sdr_dqm  = rd_dqm;
      end
      default: ;
    endcase
  end

  assign aref_en = (state == S_AREF);
  assign wr_en   = (state == S_WRITE);
  assign rd_en   = (state == S_READ);

  assign sdr_dq = (wr_en && wr_output_en) ? wr_dq : {DQ_W{1'bz}};
  assign rd_dq  = sdr_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed self-checking bench for sdram_arbit: init handoff, write, priority order, read, reset abort.
// DQ counts as released when it reads Z (or 0 on a two-state simulator) while wr_dq holds a nonzero pattern.
module tb_sdram_arbit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  init_cmds;
  logic [10:0] init_addr;
  logic [1:0]  init_ba;
  logic        init_done;
  logic        aref_req, aref_end;
  logic [3:0]  aref_cmds;
  logic [10:0] aref_addr;
  logic [1:0]  aref_ba;
  logic        aref_en;
  logic        wr_req, wr_end;
  logic [3:0]  wr_cmds;
  logic [10:0] wr_addr;
  logic [1:0]  wr_ba;
  logic [31:0] wr_dq;
  logic [3:0]  wr_dqm;
  logic        wr_output_en;
  logic        wr_en;
  logic        rd_req, rd_end;
  logic [3:0]  rd_cmds;
  logic [10:0] rd_addr;
  logic [1:0]  rd_ba;
  logic [3:0]  rd_dqm;
  logic        rd_en;
  logic [31:0] rd_dq;
  logic [3:0]  sdr_cmds;
  logic [10:0] sdr_addr;
  logic [1:0]  sdr_ba;
  logic [3:0]  sdr_dqm;
  wire  [31:0] sdr_dq;

  logic        mdl_drv;
  logic [31:0] mdl_dq;
  assign sdr_dq = mdl_drv ? mdl_dq : 32'hz;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] prio_exp [8] = '{3'b100, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000};

  always #5 clk = ~clk;

  sdram_arbit #(.ADDR_W(11), .BA_W(2), .DQ_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_cmds(init_cmds), .init_addr(init_addr), .init_ba(init_ba), .init_done(init_done),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmds(aref_cmds), .aref_addr(aref_addr),
    .aref_ba(aref_ba), .aref_en(aref_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmds(wr_cmds), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .wr_dq(wr_dq), .wr_dqm(wr_dqm), .wr_output_en(wr_output_en), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmds(rd_cmds), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .rd_dqm(rd_dqm), .rd_en(rd_en), .rd_dq(rd_dq),
    .sdr_cmds(sdr_cmds), .sdr_addr(sdr_addr), .sdr_ba(sdr_ba), .sdr_dqm(sdr_dqm), .sdr_dq(sdr_dq)
  );

  task automatic test_reset;
    rst_n = 1'b0; init_done = 1'b0;
    init_cmds = 4'h7; init_addr = 11'h400; init_ba = 2'd2;
    aref_req = 0; aref_end = 0; aref_cmds = 4'b0001; aref_addr = 11'h155; aref_ba = 2'd3;
    wr_req = 1'b1; wr_end = 0; wr_cmds = 4'b0011; wr_addr = 11'h111; wr_ba = 2'd1;
    wr_dq = 32'hDEAD_BEEF; wr_dqm = 4'b0000; wr_output_en = 1'b1;
    rd_req = 0; rd_end = 0; rd_cmds = 4'b0101; rd_addr = 11'h222; rd_ba = 2'd2; rd_dqm = 4'b1010;
    mdl_drv = 0; mdl_dq = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      n_err++; $display("FAIL reset_grants: got %b want 000", {aref_en, wr_en, rd_en});
    end
    n_cmp++;
    if ({sdr_cmds, sdr_addr, sdr_ba, sdr_dqm} !== {4'h7, 11'h400, 2'd2, 4'hF}) begin
      n_err++; $display("FAIL reset_bus: got %h/%h/%h/%h want 7/400/2/f", sdr_cmds, sdr_addr, sdr_ba, sdr_dqm);
    end
    n_cmp++;
    if (sdr_dq !== 32'hz && sdr_dq !== 32'h0) begin
      n_err++; $display("FAIL reset_dq: got %h want released", sdr_dq);
    end
    rst_n = 1'b1;
    // wr_req stays high throughout init and must be ignored until ARBIT.
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      init_cmds = c[3:0]; init_addr = c[10:0]; init_ba = c[1:0];
      init_done = (c == 200);
      if (c == 200) wr_output_en = 1'b0;
      #1;
      n_cmp++;
      if ({sdr_cmds, sdr_addr, sdr_ba, aref_en, wr_en, rd_en} !== {c[3:0], c[10:0], c[1:0], 3'b000}) begin
        n_err++; $display("FAIL init_mirror c=%0d: got %h/%h/%h en=%b want %h/%h/%h en=000",
                          c, sdr_cmds, sdr_addr, sdr_ba, {aref_en, wr_en, rd_en}, c[3:0], c[10:0], c[1:0]);
      end
    end
    @(negedge clk);
    init_done = 1'b0;
    wr_cmds = 4'b0011; wr_addr = 11'h111; wr_ba = 2'd1;
    #1;
    n_cmp++;
    if ({sdr_cmds, sdr_addr, sdr_ba, sdr_dqm} !== {4'b0111, 11'h000, 2'd0, 4'hF}) begin
      n_err++; $display("FAIL arbit_nop: got %h/%h/%h/%h want 7/000/0/f", sdr_cmds, sdr_addr, sdr_ba, sdr_dqm);
    end
    n_cmp++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      n_err++; $display("FAIL arbit_grants: got %b want 000", {aref_en, wr_en, rd_en});
    end
  endtask

  task automatic test_single_write;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      wr_req = 1'b0;
      wr_cmds = (j == 0) ? 4'b0011 : ((j == 1) ? 4'b0100 : 4'b0111);
      wr_output_en = (j >= 1 && j <= 9);
      wr_dq = (j >= 1 && j <= 9) ? 32'(9 + j) : 32'hDEAD_BEEF;
      wr_end = (j == 10);
      #1;
      n_cmp++;
      if ({wr_en, sdr_cmds, sdr_addr, sdr_ba, sdr_dqm} !== {1'b1, wr_cmds, 11'h111, 2'd1, 4'b0000}) begin
        n_err++; $display("FAIL write_bus j=%0d: en=%b %h/%h/%h/%h want en=1 %h/111/1/0",
                          j, wr_en, sdr_cmds, sdr_addr, sdr_ba, sdr_dqm, wr_cmds);
      end
      n_cmp++;
      if (j >= 1 && j <= 9) begin
        if (sdr_dq !== 32'(9 + j)) begin
          n_err++; $display("FAIL write_data j=%0d: got %h want %h", j, sdr_dq, 32'(9 + j));
        end
      end else if (sdr_dq !== 32'hz && sdr_dq !== 32'h0) begin
        n_err++; $display("FAIL write_dq_idle j=%0d: got %h want released", j, sdr_dq);
      end
    end
    @(negedge clk);
    wr_end = 1'b0;
    wr_output_en = 1'b1;
    #1;
    n_cmp++;
    if ({wr_en, sdr_cmds} !== {1'b0, 4'b0111}) begin
      n_err++; $display("FAIL write_after_end: en=%b cmds=%h want en=0 cmds=7", wr_en, sdr_cmds);
    end
    n_cmp++;
    if (sdr_dq !== 32'hz && sdr_dq !== 32'h0) begin
      n_err++; $display("FAIL write_after_end_dq: got %h want released", sdr_dq);
    end
    wr_output_en = 1'b0;
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
  endtask

  task automatic test_priority;
    logic [2:0] g;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      g = {aref_en, wr_en, rd_en};
      n_cmp++;
      if (g !== prio_exp[i]) begin
        n_err++; $display("FAIL prio_grant i=%0d: got %b want %b", i, g, prio_exp[i]);
      end
      n_cmp++;
      if ($countones(g) > 1) begin
        n_err++; $display("FAIL prio_onehot i=%0d: got %b want at most one", i, g);
      end
      if (prio_exp[i] == 3'b100) begin
        n_cmp++;
        if ({sdr_cmds, sdr_addr, sdr_ba} !== {4'b0001, 11'h155, 2'd3}) begin
          n_err++; $display("FAIL prio_aref_bus i=%0d: got %h/%h/%h want 1/155/3", i, sdr_cmds, sdr_addr, sdr_ba);
        end
      end else if (prio_exp[i] == 3'b000) begin
        n_cmp++;
        if (sdr_cmds !== 4'b0111) begin
          n_err++; $display("FAIL prio_nop i=%0d: got %h want 7", i, sdr_cmds);
        end
      end
      if (aref_en) aref_req = 1'b0;
      if (wr_en)   wr_req = 1'b0;
      if (rd_en)   rd_req = 1'b0;
      aref_end = (i == 1);
      wr_end   = (i == 3);
      rd_end   = (i == 0) || (i == 5);
    end
    @(negedge clk);
    aref_end = 0; wr_end = 0; rd_end = 0;
    aref_req = 0; wr_req = 0; rd_req = 0;
  endtask

  task automatic test_read;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    mdl_drv = 1'b1; mdl_dq = 32'h0000_000A;
    wr_output_en = 1'b1; wr_dq = 32'hDEAD_BEEF;
    wr_end = 1'b1;
    #1;
    n_cmp++;
    if ({rd_en, sdr_cmds, sdr_addr, sdr_ba, sdr_dqm} !== {1'b1, 4'b0101, 11'h222, 2'd2, 4'b1010}) begin
      n_err++; $display("FAIL read_bus: en=%b %h/%h/%h/%h want en=1 5/222/2/a",
                        rd_en, sdr_cmds, sdr_addr, sdr_ba, sdr_dqm);
    end
    n_cmp++;
    if (rd_dq !== 32'h0000_000A) begin
      n_err++; $display("FAIL read_data: got %h want 0000000a", rd_dq);
    end
    @(negedge clk);
    wr_end = 1'b0;
    #1;
    n_cmp++;
    if ({aref_en, wr_en, rd_en} !== 3'b001) begin
      n_err++; $display("FAIL read_ignores_wr_end: got %b want 001", {aref_en, wr_en, rd_en});
    end
    rd_end = 1'b1;
    @(negedge clk);
    rd_end = 1'b0;
    mdl_drv = 1'b0;
    #1;
    n_cmp++;
    if ({aref_en, wr_en, rd_en, sdr_cmds} !== {3'b000, 4'b0111}) begin
      n_err++; $display("FAIL read_after_end: en=%b cmds=%h want 000/7", {aref_en, wr_en, rd_en}, sdr_cmds);
    end
    n_cmp++;
    if (sdr_dq !== 32'hz && sdr_dq !== 32'h0) begin
      n_err++; $display("FAIL read_after_end_dq: got %h want released", sdr_dq);
    end
    wr_output_en = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0; wr_output_en = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      wr_output_en = 1'b1; wr_dq = 32'(10 + b);
    end
    #1;
    n_cmp++;
    if ({wr_en, sdr_dq} !== {1'b1, 32'd12}) begin
      n_err++; $display("FAIL abort_beat3: en=%b dq=%h want en=1 dq=0000000c", wr_en, sdr_dq);
    end
    rst_n = 1'b0;
    init_cmds = 4'b0010; init_addr = 11'h7A5; init_ba = 2'd1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      n_err++; $display("FAIL abort_grants: got %b want 000", {aref_en, wr_en, rd_en});
    end
    n_cmp++;
    if (sdr_dq !== 32'hz && sdr_dq !== 32'h0) begin
      n_err++; $display("FAIL abort_dq: got %h want released", sdr_dq);
    end
    n_cmp++;
    if ({sdr_cmds, sdr_addr, sdr_ba, sdr_dqm} !== {4'b0010, 11'h7A5, 2'd1, 4'hF}) begin
      n_err++; $display("FAIL abort_bus: got %h/%h/%h/%h want 2/7a5/1/f", sdr_cmds, sdr_addr, sdr_ba, sdr_dqm);
    end
    rst_n = 1'b1; wr_req = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({wr_en, sdr_cmds} !== {1'b0, 4'b0010}) begin
      n_err++; $display("FAIL abort_stays_init: en=%b cmds=%h want en=0 cmds=2", wr_en, sdr_cmds);
    end
    wr_req = 1'b0; wr_output_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_priority();
    test_read();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

SDRAM command-bus arbiter sitting directly downstream of `sdram_init`, `sdram_aref`, `sdram_wr` and `sdram_rd`. It grants the single SDRAM command/address/data bus to one requester at a time, with fixed priority refresh > write > read. It drives the device pins and replaces the ad-hoc `init_done` muxing in the test benches.

## Interface
- `ADDR_W`, 11, SDRAM address width (row/column).
- `BA_W`, 2, bank address width.
- `DQ_W`, 32, data bus width; DQM width is `DQ_W/8`.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  synchronous, active-low reset.
- `init_cmds` in 4, `init_addr` in ADDR_W, `init_ba` in BA_W: init-sequence bus.
- `init_done`  in  1  initialisation complete.
- `aref_req`  in  1  refresh request, level, held until granted.
- `aref_end`  in  1  one-cycle pulse, refresh sequence finished.
- `aref_cmds` in 4, `aref_addr` in ADDR_W, `aref_ba` in BA_W: refresh bus.
- `aref_en`  out  1  refresh grant.
- `wr_req`, `wr_end`  in  1 each  write request (level) and done pulse.
- `wr_cmds` in 4, `wr_addr` in ADDR_W, `wr_ba` in BA_W, `wr_dq` in DQ_W, `wr_dqm` in DQ_W/8: write bus.
- `wr_output_en`  in  1  the write stage wants DQ driven this cycle.
- `wr_en`  out  1  write grant.
- `rd_req`, `rd_end`  in  1 each  read request (level) and done pulse.
- `rd_cmds` in 4, `rd_addr` in ADDR_W, `rd_ba` in BA_W, `rd_dqm` in DQ_W/8: read bus.
- `rd_en`  out  1  read grant.
- `rd_dq`  out  DQ_W  sampled device data, a combinational copy of `sdr_dq`.
- `sdr_cmds`  out  4  {cs_n, ras_n, cas_n, we_n}.
- `sdr_addr` out ADDR_W, `sdr_ba` out BA_W, `sdr_dqm` out DQ_W/8.
- `sdr_dq`  inout  DQ_W  tri-state device data bus.

## Operation
- Registered FSM with states INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- INIT: the bus mirrors the `init_*` inputs. `init_done`=1 moves the FSM to ARBIT. All `*_req` inputs are ignored in INIT.
- ARBIT: the bus drives NOP: `sdr_cmds`=4'b0111, addr=0, ba=0. Requests sampled the same cycle:
  - `aref_req` → AREF;
  - else `wr_req` → WRITE;
  - else `rd_req` → READ;
  - else stay in ARBIT.
- AREF, WRITE, READ: the bus mirrors the granted source's cmds, addr and ba. The state holds until that source's `*_end` pulse, then returns to ARBIT. `*_end` from a non-granted source is ignored.
- Grant outputs are decoded from state: `aref_en`=(state==AREF), `wr_en`=(state==WRITE), `rd_en`=(state==READ). At most one grant is high at any time.
- `sdr_dqm` routing:
  - WRITE: `wr_dqm`;
  - READ: `rd_dqm`;
  - all other states: all ones.
- `sdr_dq` = `wr_dq` when state==WRITE and `wr_output_en`=1; otherwise high-Z. The arbiter never drives DQ in READ.
- `init_done` is consulted only in INIT. A later drop of `init_done` is ignored.
- Requesters hold `*_req` until they see their `*_en`. The arbiter does not latch requests.
- Starvation: refresh waits at most one in-flight transaction. Reads can be starved by back-to-back writes; this is accepted, and bandwidth policy belongs upstream.

## Timing
- Reset values:
  - state=INIT;
  - all `*_en`=0;
  - `sdr_dq`=Z;
  - bus outputs follow the `init_*` inputs, which are themselves in reset.
- `init_done` high at edge N → ARBIT from N+1.
- Request sampled in ARBIT at edge N → grant state and its `*_en` from N+1. The granted source's cmds appear on `sdr_cmds` in the same cycle `*_en` rises (combinational mux off the state register).
- `*_end` high at edge M → ARBIT from M+1, and `*_en` falls at M+1. This guarantees a minimum one-cycle NOP gap between transactions.
- A `*_end` and a new request in the same cycle: the new request is serviced only after the ARBIT cycle.
- `rst_n` low at any edge → INIT at the next edge, grants drop and DQ is released immediately. The in-flight burst is abandoned, and the full init sequence must complete again.

## Test plan
- Reset then `init_done` at cycle 200 → bus equals `init_*` through 200. At 201: state ARBIT, `sdr_cmds`=4'b0111, `sdr_dqm`=4'hF, all grants 0.
- Single write (`wr_req`=1, addr 'h111, ba 1, burst of 9 data 10..18) → `wr_en` rises 1 cycle after sampling.
  - `sdr_cmds`/`sdr_addr`/`sdr_ba` equal the `wr_*` inputs.
  - `sdr_dq` carries 10..18 only while `wr_output_en`=1.
  - After `wr_end`, the next cycle shows NOP and DQ=Z.
- `aref_req`, `wr_req`, `rd_req` all asserted in the same ARBIT cycle → grants in order AREF, WRITE, READ, each separated by exactly one NOP cycle, never two grants high together.
- Read with the model returning 32'h0000_000A → `sdr_dq` not driven by the arbiter, `rd_dq`=32'h0000_000A, `sdr_dqm`=`rd_dqm`.
- `wr_req` held high from reset → no `wr_en` until one cycle after ARBIT is entered; `wr_end` while in READ is ignored.
- `rst_n` pulled low mid-write (3rd data beat) → next edge: INIT, `wr_en`=0, `sdr_dq`=Z, bus mirrors `init_*`.
